// File: rtl/iir_y_receiver_if.sv
// iir_y_receiver_if: filter-output capture handshake plus FWFT result read port.
interface iir_y_receiver_if #(parameter int CNT_W = 3);
   logic [31:0]      y_data;
   logic             y_data_valid;
   logic             y_ack;
   logic [23:0]      data;
   logic             data_valid;
   logic             data_ready;
   logic [CNT_W-1:0] fifo_count;
   logic             busy;
   modport master (output y_data, y_data_valid, data_ready,
                   input  y_ack, data, data_valid, fifo_count, busy);
   modport slave  (input  y_data, y_data_valid, data_ready,
                   output y_ack, data, data_valid, fifo_count, busy);
endinterface

// File: rtl/iir_y_receiver.sv
// iir_y_receiver: captures float32 filter samples, converts them to saturated
// signed 24-bit fixed point with a one-bit-per-cycle shifter, and queues them in a FWFT FIFO.
module iir_y_receiver #(
   parameter int FRAC_BITS = 0,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = 3
) (
   input logic             i_CLK,
   input logic             i_RSTN,
   iir_y_receiver_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [2:0] {ST_IDLE, ST_DECODE, ST_SHIFT, ST_SIGN, ST_PUSH} state_t;
   state_t state, nxt;
   logic [31:0] sample;
   logic [23:0] mag, result;
   logic [4:0] cnt, cnt0;
   logic ack, cap, zero, sat, full, push, pop;
   logic signed [9:0] e;
   logic [23:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   assign e    = $signed({2'b00, sample[30:23]}) + 10'(FRAC_BITS - 127);
   assign cnt0 = 5'(10'sd23 - e);
   assign zero = sample[30:23] == 8'd0 || e < 0;
   assign sat  = sample[30:23] == 8'hFF || e >= 10'sd23;
   // the !ack term keeps a still-high VALID from being captured twice
   assign cap  = state == ST_IDLE && bus.y_data_valid && !ack;
   assign full = count == CNT_W'(DEPTH);
   assign push = state == ST_PUSH && !full;
   assign pop  = count != '0 && bus.data_ready;
   always_ff @(posedge i_CLK or negedge i_RSTN)
      if (!i_RSTN) state <= ST_IDLE;
      else         state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:   nxt = cap ? ST_DECODE : ST_IDLE;
         ST_DECODE: nxt = (zero || sat) ? ST_PUSH : (cnt0 != 5'd0 ? ST_SHIFT : ST_SIGN);
         ST_SHIFT:  nxt = cnt == 5'd1 ? ST_SIGN : ST_SHIFT;
         ST_SIGN:   nxt = ST_PUSH;
         ST_PUSH:   nxt = full ? ST_PUSH : ST_IDLE;
         default:   nxt = ST_IDLE;
      endcase
   end
   always_ff @(posedge i_CLK or negedge i_RSTN)
      if (!i_RSTN) begin
         ack    <= 1'b0;
         sample <= '0;
         mag    <= '0;
         cnt    <= '0;
         result <= '0;
      end else begin
         ack <= cap;
         if (cap) sample <= bus.y_data;
         if (state == ST_DECODE) begin
            mag    <= {1'b1, sample[22:0]};
            cnt    <= cnt0;
            result <= zero ? 24'd0 : sat ? (sample[31] ? 24'h800000 : 24'h7FFFFF) : result;
         end
         if (state == ST_SHIFT) begin
            mag <= mag >> 1;
            cnt <= cnt - 5'd1;
         end
         if (state == ST_SIGN) result <= sample[31] ? -mag : mag;
      end
   always_ff @(posedge i_CLK or negedge i_RSTN)
      if (!i_RSTN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   always_ff @(posedge i_CLK)
      if (push) mem[wr_ptr] <= result;
   assign bus.y_ack      = ack;
   assign bus.data       = count != '0 ? mem[rd_ptr] : 24'd0;
   assign bus.data_valid = count != '0;
   assign bus.fifo_count = count;
   assign bus.busy       = state != ST_IDLE;
endmodule

// File: tb/tb_iir_y_receiver.sv
// tb_iir_y_receiver: directed float32 vectors; expected fixed-point results go
// into a scoreboard queue that a negedge monitor pops as the FIFO is read.
module tb_iir_y_receiver;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int cyc = 0, n_chk = 0, n_bad = 0, acks = 0, cap_cyc = 0, a0 = 0;
   logic [23:0] sb [$];
   logic [31:0] sat_in [4] = '{32'h4B000000, 32'hCB000000, 32'h7F800000, 32'hFFC00000};
   logic [23:0] sat_ex [4] = '{24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000};
   logic [31:0] bp_in  [6] = '{32'h40400000, 32'h4B000000, 32'hC0200000, 32'h7F800000, 32'h3F800000, 32'hCB000000};
   logic [23:0] bp_ex  [6] = '{24'h000003, 24'h7FFFFF, 24'hFFFFFE, 24'h7FFFFF, 24'h000001, 24'h800000};
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   iir_y_receiver_if #(.CNT_W(3)) if0 ();
   iir_y_receiver_if #(.CNT_W(3)) if1 ();
   iir_y_receiver #(.FRAC_BITS(0), .DEPTH(4), .CNT_W(3)) u0 (.i_CLK(clk), .i_RSTN(rst_n), .bus(if0));
   iir_y_receiver #(.FRAC_BITS(8), .DEPTH(4), .CNT_W(3)) u1 (.i_CLK(clk), .i_RSTN(rst_n), .bus(if1));
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   always @(negedge clk) if (rst_n && if0.y_ack) acks++;
   always @(negedge clk)
      if (rst_n && if0.data_valid && if0.data_ready) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL unexpected_out: got %h expected nothing", if0.data);
         end else chk("fifo_out", {8'd0, if0.data}, {8'd0, sb.pop_front()});
      end
   task automatic send(input logic [31:0] d, input logic [23:0] x);
      bit got = 1'b0;
      if0.y_data = d;
      if0.y_data_valid = 1'b1;
      sb.push_back(x);
      for (int n = 0; n < 2000 && !got; n++) begin
         @(negedge clk);
         got = if0.y_ack;
      end
      cap_cyc = cyc;
      if (!got) chk("ack_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 if0.y_data_valid = 1'b0;
   endtask
   task automatic wait_neg(input int n);
      do @(negedge clk); while (cyc < n);
   endtask
   task automatic drain();
      for (int n = 0; n < 1000 && (sb.size() != 0 || if0.busy); n++) @(negedge clk);
      chk("drain_empty", sb.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      if0.y_data = '0; if0.y_data_valid = 1'b0; if0.data_ready = 1'b0;
      if1.y_data = '0; if1.y_data_valid = 1'b0; if1.data_ready = 1'b0;
      #7;
      chk("rst_ack",   {31'd0, if0.y_ack}, 32'd0);
      chk("rst_data",  {8'd0, if0.data}, 32'd0);
      chk("rst_valid", {31'd0, if0.data_valid}, 32'd0);
      chk("rst_count", {29'd0, if0.fifo_count}, 32'd0);
      chk("rst_busy",  {31'd0, if0.busy}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 if0.data_ready = 1'b1;
      a0 = acks;
      send(32'h3F800000, 24'h000001);
      wait_neg(cap_cyc + 25);
      chk("lat26_before", {31'd0, if0.data_valid}, 32'd0);
      chk("lat26_busy", {31'd0, if0.busy}, 32'd1);
      wait_neg(cap_cyc + 26);
      chk("lat26_valid", {31'd0, if0.data_valid}, 32'd1);
      drain();
      chk("single_ack", acks - a0, 32'd1);
      send(32'hC0200000, 24'hFFFFFE);
      send(32'h3F000000, 24'h000000);
      send(32'h00000000, 24'h000000);
      send(32'h00000001, 24'h000000);
      drain();
      for (int i = 0; i < 4; i++) begin
         send(sat_in[i], sat_ex[i]);
         wait_neg(cap_cyc + 1);
         chk("lat2_before", {31'd0, if0.data_valid}, 32'd0);
         wait_neg(cap_cyc + 2);
         chk("lat2_valid", {31'd0, if0.data_valid}, 32'd1);
         drain();
      end
      if0.data_ready = 1'b0;
      a0 = acks;
      fork
         for (int i = 0; i < 6; i++) send(bp_in[i], bp_ex[i]);
         begin
            repeat (150) @(posedge clk);
            @(negedge clk);
            chk("bp_count", {29'd0, if0.fifo_count}, 32'd4);
            chk("bp_busy", {31'd0, if0.busy}, 32'd1);
            chk("bp_acks", acks - a0, 32'd5);
            @(posedge clk);
            #1 if0.data_ready = 1'b1;
         end
      join
      drain();
      chk("bp_count_end", {29'd0, if0.fifo_count}, 32'd0);
      chk("bp_acks_end", acks - a0, 32'd6);
      if0.data_ready = 1'b0;
      send(32'h4B000000, 24'h7FFFFF);
      send(32'hCB000000, 24'h800000);
      send(32'h3F800000, 24'h000001);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_count", {29'd0, if0.fifo_count}, 32'd2);
      chk("pre_rst_busy", {31'd0, if0.busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ack",   {31'd0, if0.y_ack}, 32'd0);
      chk("arst_data",  {8'd0, if0.data}, 32'd0);
      chk("arst_valid", {31'd0, if0.data_valid}, 32'd0);
      chk("arst_count", {29'd0, if0.fifo_count}, 32'd0);
      chk("arst_busy",  {31'd0, if0.busy}, 32'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(32'h40000000, 24'h000002);
      for (int n = 0; n < 100 && !if0.data_valid; n++) @(negedge clk);
      chk("post_rst_count", {29'd0, if0.fifo_count}, 32'd1);
      chk("post_rst_head", {8'd0, if0.data}, 32'h000002);
      @(posedge clk);
      #1 if0.data_ready = 1'b1;
      drain();
      if1.y_data = 32'h3FC00000;
      if1.y_data_valid = 1'b1;
      for (int n = 0; n < 100 && !if1.y_ack; n++) @(negedge clk);
      chk("frac8_ack", {31'd0, if1.y_ack}, 32'd1);
      @(posedge clk);
      #1 if1.y_data_valid = 1'b0;
      for (int n = 0; n < 100 && !if1.data_valid; n++) @(negedge clk);
      chk("frac8_data", {8'd0, if1.data}, 32'h000180);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end
endmodule
